// File: rtl/mem_wb_pipeline.sv
// MEM->WB pipeline register with writeback result selection and a 64-bit retired-instruction counter.
// Flush beats stall; counter clear beats a coincident increment.
module mem_wb_pipeline #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  cnt_clr_i,
  input  logic                  ValidM_i,
  input  logic                  RegWriteM_i,
  input  logic [1:0]            ResultSrcM_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] ReadDataM_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4M_i,
  input  logic [4:0]            RdM_i,
  output logic                  ValidW_o,
  output logic                  RegWriteW_o,
  output logic [4:0]            RdW_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [63:0]           RetireCnt_o
);

  logic                  r_valid;
  logic                  r_regWrite;
  logic [1:0]            r_resultSrc;
  logic [DATA_WIDTH-1:0] r_aluResult;
  logic [DATA_WIDTH-1:0] r_readData;
  logic [DATA_WIDTH-1:0] r_pcPlus4;
  logic [4:0]            r_rd;
  logic [63:0]           r_retireCnt;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_capture = en_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_resultSrc <= 2'b00;
      r_aluResult <= '0;
      r_readData  <= '0;
      r_pcPlus4   <= '0;
      r_rd        <= 5'd0;
    end else if (flush_i) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_resultSrc <= 2'b00;
      r_aluResult <= '0;
      r_readData  <= '0;
      r_pcPlus4   <= '0;
      r_rd        <= 5'd0;
    end else if (en_i) begin
      r_valid     <= ValidM_i;
      r_regWrite  <= RegWriteM_i;
      r_resultSrc <= ResultSrcM_i;
      r_aluResult <= ALUResultM_i;
      r_readData  <= ReadDataM_i;
      r_pcPlus4   <= PCPlus4M_i;
      r_rd        <= RdM_i;
    end
  end

  // Each instruction is counted once, at the edge that captures it into W.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_retireCnt <= 64'd0;
    end else if (cnt_clr_i) begin
      r_retireCnt <= 64'd0;
    end else if (w_capture && ValidM_i) begin
      r_retireCnt <= r_retireCnt + 64'd1;
    end
  end

  always_comb begin
    w_result = '0;
    case (r_resultSrc)
      2'b00:   w_result = r_aluResult;
      2'b01:   w_result = r_readData;
      2'b10:   w_result = r_pcPlus4;
      default: w_result = '0;
    endcase
  end

  // Writes to x0 are suppressed here so the register file never sees them.
  assign RegWriteW_o = r_regWrite & r_valid & (r_rd != 5'd0);
  assign ValidW_o    = r_valid;
  assign RdW_o       = r_rd;
  assign ResultW_o   = w_result;
  assign RetireCnt_o = r_retireCnt;

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Self-checking bench for mem_wb_pipeline: directed scenarios plus randomized traffic
// compared against a transaction-level model of the writeback stage and retire counter.
module tb_mem_wb_pipeline;

   localparam int DW = 32;

   logic          clk;
   logic          rst_ni;
   logic          enI;
   logic          flushI;
   logic          cntClrI;
   logic          validM;
   logic          regWriteM;
   logic [1:0]    resultSrcM;
   logic [DW-1:0] aluResultM;
   logic [DW-1:0] readDataM;
   logic [DW-1:0] pcPlus4M;
   logic [4:0]    rdM;
   logic          validW;
   logic          regWriteW;
   logic [4:0]    rdW;
   logic [DW-1:0] resultW;
   logic [63:0]   retireCnt;

   int total;
   int bad;

   // Model of the instruction currently sitting in writeback, kept as final values.
   bit               expValid;
   bit               expRegWrite;
   bit [4:0]         expRd;
   bit [DW-1:0]      expResult;
   longint unsigned  expCount;

   mem_wb_pipeline #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst_ni       (rst_ni),
      .en_i         (enI),
      .flush_i      (flushI),
      .cnt_clr_i    (cntClrI),
      .ValidM_i     (validM),
      .RegWriteM_i  (regWriteM),
      .ResultSrcM_i (resultSrcM),
      .ALUResultM_i (aluResultM),
      .ReadDataM_i  (readDataM),
      .PCPlus4M_i   (pcPlus4M),
      .RdM_i        (rdM),
      .ValidW_o     (validW),
      .RegWriteW_o  (regWriteW),
      .RdW_o        (rdW),
      .ResultW_o    (resultW),
      .RetireCnt_o  (retireCnt)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output against the model.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".valid"},    64'(validW),    64'(expValid));
      checkOutput({tag, ".regWrite"}, 64'(regWriteW), 64'(expRegWrite && expValid && expRd != 5'd0));
      checkOutput({tag, ".rd"},       64'(rdW),       64'(expRd));
      checkOutput({tag, ".result"},   64'(resultW),   64'(expResult));
      checkOutput({tag, ".count"},    retireCnt,      expCount);
   endtask

   task automatic resetModel();
      expValid    = 1'b0;
      expRegWrite = 1'b0;
      expRd       = 5'd0;
      expResult   = '0;
      expCount    = 64'd0;
   endtask

   // Drives one cycle of inputs, waits for the capture edge, advances the model,
   // and returns at the following falling edge where outputs are sampled.
   task automatic applyStimulus(input bit en, input bit flush, input bit clr, input bit valid,
                                input bit regWrite, input bit [1:0] src, input bit [DW-1:0] alu,
                                input bit [DW-1:0] rdata, input bit [DW-1:0] pc4, input bit [4:0] rd);
      enI        = en;
      flushI     = flush;
      cntClrI    = clr;
      validM     = valid;
      regWriteM  = regWrite;
      resultSrcM = src;
      aluResultM = alu;
      readDataM  = rdata;
      pcPlus4M   = pc4;
      rdM        = rd;
      @(posedge clk);
      if (clr)
         expCount = 64'd0;
      else if (en && !flush && valid)
         expCount = expCount + 64'd1;
      if (flush) begin
         expValid    = 1'b0;
         expRegWrite = 1'b0;
         expRd       = 5'd0;
         expResult   = '0;
      end else if (en) begin
         expValid    = valid;
         expRegWrite = regWrite;
         expRd       = rd;
         expResult   = (src == 2'd0) ? alu : (src == 2'd1) ? rdata : (src == 2'd2) ? pc4 : '0;
      end
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_ni = 1'b0;
      applyInputsIdle();
      resetModel();
      @(negedge clk);
      @(negedge clk);
      checkAll("reset");
      rst_ni = 1'b1;

      // Load-data capture.
      applyStimulus(1, 0, 0, 1, 1, 2'b01, 32'h1111, 32'hDEADBEEF, 32'h4, 5'd5);
      checkAll("capture");
      checkOutput("capture.literal", 64'(resultW), 64'hDEADBEEF);
      checkOutput("capture.cnt1", retireCnt, 64'd1);

      // Write to x0 must be suppressed but still counted.
      applyStimulus(1, 0, 0, 1, 1, 2'b00, 32'h10, 32'h0, 32'h0, 5'd0);
      checkAll("x0");
      checkOutput("x0.regWrite", 64'(regWriteW), 64'd0);

      // Capture then stall three cycles with changing inputs.
      applyStimulus(1, 0, 0, 1, 1, 2'b10, 32'h55, 32'h66, 32'h104, 5'd7);
      checkAll("preStall");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 2'(i), $urandom, $urandom, $urandom, 5'(i + 9));
         checkAll("stall");
         checkOutput("stall.result", 64'(resultW), 64'h104);
         checkOutput("stall.rd", 64'(rdW), 64'd7);
      end

      // Flush wins over stall.
      applyStimulus(0, 1, 0, 1, 1, 2'b00, 32'hABCD, 32'h0, 32'h0, 5'd3);
      checkAll("flushStall");
      checkOutput("flushStall.valid", 64'(validW), 64'd0);

      // Bring the counter to 9, then clear on a valid capture.
      applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
      for (int i = 0; i < 9; i++)
         applyStimulus(1, 0, 0, 1, 0, 2'b00, 32'(i), 32'h0, 32'h0, 5'd1);
      checkOutput("clr.pre", retireCnt, 64'd9);
      applyStimulus(1, 0, 1, 1, 1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd12);
      checkAll("clr");
      checkOutput("clr.zero", retireCnt, 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                       2'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
         checkAll("rand");
      end

      // Async reset mid-stall with count=3 and a valid instruction in W.
      applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 1, 1, 2'b00, 32'(i + 100), 32'h0, 32'h0, 5'd4);
      applyStimulus(0, 0, 0, 1, 1, 2'b01, 32'h0, 32'h99, 32'h0, 5'd8);
      checkOutput("preReset.count", retireCnt, 64'd3);
      checkOutput("preReset.valid", 64'(validW), 64'd1);
      #2;
      rst_ni = 1'b0;
      resetModel();
      #1;
      checkAll("asyncReset");
      @(negedge clk);
      rst_ni = 1'b1;
      applyStimulus(1, 0, 0, 1, 1, 2'b11, 32'hFFFF, 32'hEEEE, 32'hDDDD, 5'd6);
      checkAll("reserved");
      checkOutput("reserved.result", 64'(resultW), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic applyInputsIdle();
      enI        = 1'b0;
      flushI     = 1'b0;
      cntClrI    = 1'b0;
      validM     = 1'b0;
      regWriteM  = 1'b0;
      resultSrcM = 2'b00;
      aluResultM = '0;
      readDataM  = '0;
      pcPlus4M   = '0;
      rdM        = 5'd0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
